// File: rtl/bus_pkg.sv
// bus_pkg: shared widths, write-request entry type and select decoder
// for the destination-side bus write demux.
package bus_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_DEST = 32;
    localparam int SEL_W    = 5;
    localparam int DEPTH    = 2;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    function automatic logic [NUM_DEST-1:0] onehot_dec(input logic [SEL_W-1:0] sel);
        return {{(NUM_DEST-1){1'b0}}, 1'b1} << sel;
    endfunction

endpackage

// File: rtl/write_queue.sv
// write_queue: DEPTH-entry synchronous FIFO of write requests with flush;
// the caller must not push while full or pop while empty.
module write_queue
    import bus_pkg::*;
#(
    parameter int DEPTH = bus_pkg::DEPTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  wr_entry_t                wdata_i,
    output wr_entry_t                rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wr_entry_t         mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    // Pointers are exactly PW bits wide, so increments wrap modulo DEPTH.
    always_comb begin
        wr_ptr_d = flush_i ? '0 : (push_i ? wr_ptr_q + 1'b1 : wr_ptr_q);
        rd_ptr_d = flush_i ? '0 : (pop_i ? rd_ptr_q + 1'b1 : rd_ptr_q);
        count_d  = flush_i ? '0 : count_q + CW'(push_i) - CW'(pop_i);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i)
            mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/bus_write_demux.sv
// bus_write_demux: queues (select, data) write requests and drains them as a
// one-hot load strobe plus shared data word to 32 destination registers.
module bus_write_demux
    import bus_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [SEL_W-1:0]     wr_select,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 enable,
    input  logic                 flush,
    output logic [NUM_DEST-1:0]  load_en,
    output logic [DATA_W-1:0]    load_data,
    output logic                 busy
);

    wr_entry_t                 wr_entry, head;
    logic [$clog2(DEPTH):0]    count;
    logic                      full, empty, push, pop;
    logic [NUM_DEST-1:0]       load_en_q, load_en_d;
    logic [DATA_W-1:0]         load_data_q, load_data_d;

    assign wr_entry = '{sel: wr_select, data: wr_data};
    assign wr_ready = !full && reset_n;
    // Flush wins over both sides of the handshake on the same edge.
    assign push     = wr_valid && wr_ready && !flush;
    assign pop      = enable && !empty && !flush;

    write_queue #(.DEPTH(DEPTH)) u_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        load_en_d   = pop ? onehot_dec(head.sel) : '0;
        load_data_d = pop ? head.data : load_data_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_en_q   <= '0;
            load_data_q <= '0;
        end else begin
            load_en_q   <= load_en_d;
            load_data_q <= load_data_d;
        end
    end

    assign load_en   = load_en_q;
    assign load_data = load_data_q;
    assign busy      = (count != '0) || (load_en_q != '0);

endmodule

// File: tb/tb_bus_write_demux.sv
// tb_bus_write_demux: directed and random stimulus checked against a
// queue-based behavioural model of the write demux.
module tb_bus_write_demux;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [4:0]  wr_select = '0;
    logic [31:0] wr_data = '0;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] load_en;
    logic [31:0] load_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  s;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_en = '0;
    logic [31:0] m_data = '0;

    always #5 clk = ~clk;

    bus_write_demux dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_select (wr_select),
        .wr_data   (wr_data),
        .enable    (enable),
        .flush     (flush),
        .load_en   (load_en),
        .load_data (load_data),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".load_en"}, 64'(load_en), 64'(m_en));
        chk({tag, ".load_data"}, 64'(load_data), 64'(m_data));
        chk({tag, ".busy"}, 64'(busy), 64'((mq.size() != 0) || (m_en != 0)));
        chk({tag, ".wr_ready"}, 64'(wr_ready), 64'(mq.size() < 2));
    endtask

    // One clock: drive inputs mid-cycle, advance the model at the edge, check after it.
    task automatic step(input string tag, input logic v, input logic [4:0] s,
                        input logic [31:0] d, input logic en, input logic fl);
        logic ready;
        ent_t h;
        wr_valid = v; wr_select = s; wr_data = d; enable = en; flush = fl;
        #1;
        ready = (mq.size() < 2);
        chk({tag, ".pre_ready"}, 64'(wr_ready), 64'(ready));
        @(posedge clk);
        if (fl) begin
            mq.delete();
            m_en = '0;
        end else begin
            if (en && mq.size() > 0) begin
                h = mq.pop_front();
                m_en = 32'h1 << h.s;
                m_data = h.d;
            end else begin
                m_en = '0;
            end
            if (v && ready) mq.push_back('{s, d});
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        wr_valid = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst.wr_ready", 64'(wr_ready), 64'd0);
        chk("rst.load_en", 64'(load_en), 64'd0);
        chk("rst.load_data", 64'(load_data), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        wr_valid = 1'b0;
        reset_n = 1'b1;
        #1;
        chk("rst.release_ready", 64'(wr_ready), 64'd1);
        @(posedge clk);
        #1;

        step("single.push", 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0);
        step("single.pop", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        chk("single.onehot", 64'(load_en), 64'h20);
        chk("single.data", 64'(load_data), 64'hDEADBEEF);
        step("single.idle", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        chk("single.held", 64'(load_data), 64'hDEADBEEF);

        step("bp.push0", 1'b1, 5'd0, 32'h1, 1'b0, 1'b0);
        step("bp.push31", 1'b1, 5'd31, 32'h2, 1'b0, 1'b0);
        chk("bp.full_ready", 64'(wr_ready), 64'd0);
        step("bp.drain0", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        chk("bp.en0", 64'(load_en), 64'h1);
        step("bp.drain31", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        chk("bp.en31", 64'(load_en), 64'h80000000);
        chk("bp.data31", 64'(load_data), 64'h2);
        step("bp.idle", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);

        step("full.fill_a", 1'b1, 5'd3, 32'hA, 1'b0, 1'b0);
        step("full.fill_b", 1'b1, 5'd4, 32'hB, 1'b0, 1'b0);
        step("full.pushpop", 1'b1, 5'd7, 32'hC, 1'b1, 1'b0);
        chk("full.ready_after", 64'(wr_ready), 64'd1);
        step("full.next", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        chk("full.order", 64'(load_data), 64'hB);
        step("full.empty", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);

        step("flush.fill_a", 1'b1, 5'd8, 32'h11, 1'b0, 1'b0);
        step("flush.fill_b", 1'b1, 5'd9, 32'h22, 1'b0, 1'b0);
        step("flush.full_drop", 1'b1, 5'd12, 32'h33, 1'b1, 1'b1);
        step("flush.after", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        step("flush.empty_ready", 1'b1, 5'd13, 32'h44, 1'b1, 1'b1);
        chk("flush.busy", 64'(busy), 64'd0);
        step("flush.dropped", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);

        step("arst.push", 1'b1, 5'd10, 32'h55, 1'b0, 1'b0);
        step("arst.push2", 1'b1, 5'd11, 32'h66, 1'b0, 1'b0);
        step("arst.pop", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        chk("arst.en10", 64'(load_en), 64'h400);
        enable = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst.async_en", 64'(load_en), 64'd0);
        chk("arst.busy", 64'(busy), 64'd0);
        mq.delete();
        m_en = '0;
        m_data = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        step("arst.after", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);

        for (int i = 0; i < 400; i++)
            step("rand", 1'($urandom_range(0, 3) != 0), 5'($urandom), $urandom,
                 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
        for (int i = 0; i < 4; i++)
            step("final.drain", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
